// File: rtl/uart_tx_drain.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_drain
//  Description : Pops bytes from a registered-read FIFO and shifts each one
//                out on txd_o as an 8N1 UART frame (start, 8 data LSB first,
//                stop). Serial line is registered and idles high.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_drain #(
    parameter int CLK_DIV   = 434,
    parameter int DIV_WIDTH = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       tx_en_i,
    input  logic       fifo_empty_i,
    input  logic [7:0] fifo_data_i,
    output logic       fifo_ren_o,
    output logic       txd_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam logic [DIV_WIDTH-1:0] C_BAUD_LAST = DIV_WIDTH'(CLK_DIV - 1);
    localparam logic [DIV_WIDTH-1:0] C_BAUD_ONE  = DIV_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_START = 3'd2,
        S_DATA  = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DIV_WIDTH-1:0]  r_baud;
    logic [DIV_WIDTH-1:0]  w_baud_nxt;
    logic [7:0]            r_shift;
    logic [7:0]            w_shift_nxt;
    logic [2:0]            r_bit_idx;
    logic [2:0]            w_bit_idx_nxt;
    logic                  r_txd;
    logic                  w_txd_nxt;
    logic                  w_ren;
    logic                  w_done;
    logic                  w_bit_end;

    assign w_bit_end = (r_baud == C_BAUD_LAST);

    // Next-state, datapath and output decode; the line level for the next
    // cycle is derived from the next state so txd_o can be a plain register.
    always_comb begin
        w_state_nxt   = r_state;
        w_baud_nxt    = r_baud;
        w_shift_nxt   = r_shift;
        w_bit_idx_nxt = r_bit_idx;
        w_ren         = 1'b0;
        w_done        = 1'b0;
        w_txd_nxt     = 1'b1;

        case (r_state)
            S_IDLE: begin
                w_baud_nxt = '0;
                w_ren      = tx_en_i & ~fifo_empty_i;
                if (w_ren) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                w_shift_nxt = fifo_data_i;
                w_baud_nxt  = '0;
                w_state_nxt = S_START;
            end
            S_START: begin
                if (w_bit_end) begin
                    w_baud_nxt    = '0;
                    w_bit_idx_nxt = 3'd0;
                    w_state_nxt   = S_DATA;
                end else begin
                    w_baud_nxt = r_baud + C_BAUD_ONE;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_baud_nxt    = '0;
                    w_shift_nxt   = {1'b0, r_shift[7:1]};
                    w_bit_idx_nxt = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end
                end else begin
                    w_baud_nxt = r_baud + C_BAUD_ONE;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_baud_nxt  = '0;
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_baud_nxt = r_baud + C_BAUD_ONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_baud_nxt  = '0;
            end
        endcase

        case (w_state_nxt)
            S_START: w_txd_nxt = 1'b0;
            S_DATA:  w_txd_nxt = w_shift_nxt[0];
            default: w_txd_nxt = 1'b1;
        endcase
    end

    // State and datapath registers; reset abandons any frame in flight.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state   <= S_IDLE;
            r_baud    <= '0;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_txd     <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_baud    <= w_baud_nxt;
            r_shift   <= w_shift_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_txd     <= w_txd_nxt;
        end
    end

    // Read request is masked while reset is held so no byte is popped then.
    assign fifo_ren_o = w_ren & rst_i;
    assign txd_o      = r_txd;
    assign busy_o     = (r_state != S_IDLE);
    assign done_o     = w_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_drain.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_drain
//  Description : Self-checking bench for uart_tx_drain with a queue-based
//                FIFO, a frame-timing reference model and a line receiver.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_drain;

    localparam int CD    = 4;
    localparam int FRAME = 10 * CD + 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tx_en = 1'b0;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_data = 8'h00;
    logic       ren, txd, busy, done;

    int n_pass = 0;
    int n_total = 0;

    logic [7:0] fifo_q[$];
    logic [7:0] model_q[$];
    int         ren_cycles[$];
    int         done_cycles[$];

    int         cyc = 0;
    bit         m_active = 0;
    int         m_start = 0;
    logic [7:0] m_byte = 8'h00;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;   // bit0 = start bit ... bit9 = stop bit
    } vec_t;
    vec_t vecs[6];

    uart_tx_drain #(.CLK_DIV(CD), .DIV_WIDTH(16)) dut (
        .clk_i        (clk),
        .rst_i        (rst_n),
        .tx_en_i      (tx_en),
        .fifo_empty_i (fifo_empty),
        .fifo_data_i  (fifo_data),
        .fifo_ren_o   (ren),
        .txd_o        (txd),
        .busy_o       (busy),
        .done_o       (done)
    );

    always #5 clk = ~clk;

    // Bench FIFO: registered read data, valid the cycle after the request.
    always @(posedge clk) begin
        if (ren && fifo_q.size() > 0) begin
            fifo_empty <= (fifo_q.size() <= 1);
            fifo_data  <= fifo_q.pop_front();
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic push(input logic [7:0] b);
        fifo_q.push_back(b);
        model_q.push_back(b);
        fifo_empty <= 1'b0;
    endtask

    task automatic nclk();
        @(negedge clk);
        #1;
    endtask

    task automatic pclk();
        @(posedge clk);
        #1;
    endtask

    // Line level / busy / done for a frame whose read request was at offset 0.
    function automatic void frame_out(input int off, input logic [7:0] b,
                                      output logic etxd, output logic ebusy, output logic edone);
        if (off < 2)                etxd = 1'b1;
        else if (off < 2 + CD)      etxd = 1'b0;
        else if (off < 2 + 9 * CD)  etxd = b[(off - 2) / CD - 1];
        else                        etxd = 1'b1;
        ebusy = (off >= 1) && (off <= 1 + 10 * CD);
        edone = (off == 1 + 10 * CD);
    endfunction

    // Cycle-by-cycle reference check of every output.
    initial begin
        logic etxd, ebusy, edone, eren;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) m_active = 0;
            else if (m_active && (cyc - m_start) > 1 + 10 * CD) m_active = 0;
            if (m_active) frame_out(cyc - m_start, m_byte, etxd, ebusy, edone);
            else begin etxd = 1'b1; ebusy = 1'b0; edone = 1'b0; end
            eren = rst_n && !m_active && tx_en && (model_q.size() > 0);
            chk("model_ren", ren, eren);
            chk("model_txd", txd, etxd);
            chk("model_busy", busy, ebusy);
            chk("model_done", done, edone);
            if (ren) ren_cycles.push_back(cyc);
            if (done) done_cycles.push_back(cyc);
            if (eren) begin
                m_active = 1;
                m_start  = cyc;
                m_byte   = model_q.pop_front();
            end
        end
    end

    task automatic wait_idle(input int limit);
        int i;
        for (i = 0; i < limit; i++) begin
            nclk();
            if (!busy && !m_active && (model_q.size() == 0 || !tx_en)) break;
        end
        chk("idle_timeout", (i < limit), 1'b1);
    endtask

    task automatic wait_ren(input int k, input int limit);
        int i;
        for (i = 0; i < limit; i++) begin
            if (ren_cycles.size() >= k) break;
            nclk();
        end
        chk("ren_timeout", (ren_cycles.size() >= k), 1'b1);
    endtask

    // Line receiver: finds the start edge and samples each bit at mid-bit.
    task automatic rx_frame(output logic [9:0] w);
        int i;
        w = '0;
        for (i = 0; i < 4 * FRAME; i++) begin
            if (txd === 1'b0) break;
            nclk();
        end
        chk("rx_start_timeout", (i < 4 * FRAME), 1'b1);
        repeat (CD / 2) nclk();
        w[0] = txd;
        for (int k = 1; k < 10; k++) begin
            repeat (CD) nclk();
            w[k] = txd;
        end
    endtask

    initial begin
        logic [9:0] w;
        int n0;

        vecs[0] = '{data: 8'hA5, frame: 10'h34A};
        vecs[1] = '{data: 8'h00, frame: 10'h200};
        vecs[2] = '{data: 8'hFF, frame: 10'h3FE};
        vecs[3] = '{data: 8'h55, frame: 10'h2AA};
        vecs[4] = '{data: 8'h3C, frame: 10'h278};
        vecs[5] = '{data: 8'h81, frame: 10'h302};

        // Reset held with a non-empty FIFO and transmit enabled.
        tx_en = 1'b1;
        push(8'hC3);
        for (int i = 0; i < 3; i++) begin
            nclk();
            chk("rst_txd", txd, 1'b1);
            chk("rst_ren", ren, 1'b0);
            chk("rst_busy", busy, 1'b0);
            chk("rst_done", done, 1'b0);
        end
        pclk();
        rst_n = 1'b1;
        wait_idle(3 * FRAME);

        // Table of single frames decoded by the receiver.
        for (int v = 0; v < 6; v++) begin
            pclk();
            push(vecs[v].data);
            rx_frame(w);
            chk("frame_bits", w, vecs[v].frame);
            wait_idle(3 * FRAME);
        end

        // Single byte: one read, done latency from the read cycle.
        ren_cycles.delete();
        done_cycles.delete();
        pclk();
        push(8'hA5);
        wait_idle(3 * FRAME);
        chk("single_ren_count", ren_cycles.size(), 1);
        chk("single_done_count", done_cycles.size(), 1);
        if (ren_cycles.size() == 1 && done_cycles.size() == 1)
            chk("single_done_lat", done_cycles[0] - ren_cycles[0], 1 + 10 * CD);
        chk("single_fifo_empty", fifo_empty, 1'b1);

        // Back-to-back bytes.
        ren_cycles.delete();
        pclk();
        push(8'h00);
        push(8'hFF);
        push(8'h55);
        rx_frame(w);
        chk("b2b_byte0", w[8:1], 8'h00);
        rx_frame(w);
        chk("b2b_byte1", w[8:1], 8'hFF);
        rx_frame(w);
        chk("b2b_byte2", w[8:1], 8'h55);
        wait_idle(3 * FRAME);
        chk("b2b_ren_count", ren_cycles.size(), 3);
        if (ren_cycles.size() == 3) begin
            chk("b2b_gap01", ren_cycles[1] - ren_cycles[0], FRAME);
            chk("b2b_gap12", ren_cycles[2] - ren_cycles[1], FRAME);
        end

        // Enable gating.
        ren_cycles.delete();
        pclk();
        push(8'h12);
        push(8'h34);
        wait_ren(1, 2 * FRAME);
        repeat (10) pclk();
        tx_en = 1'b0;
        repeat (2 * FRAME) nclk();
        chk("gate_ren_count", ren_cycles.size(), 1);
        chk("gate_busy", busy, 1'b0);
        pclk();
        tx_en = 1'b1;
        nclk();
        chk("gate_ren_resume", ren, 1'b1);
        wait_idle(3 * FRAME);

        // Empty FIFO.
        ren_cycles.delete();
        repeat (100) nclk();
        chk("empty_ren_count", ren_cycles.size(), 0);
        chk("empty_txd", txd, 1'b1);
        chk("empty_busy", busy, 1'b0);

        // Reset during data bit 3, checked before any clock edge.
        ren_cycles.delete();
        pclk();
        push(8'h81);
        wait_ren(1, 2 * FRAME);
        n0 = cyc;
        repeat (2 + 4 * CD + 1 - (cyc - ren_cycles[0])) nclk();
        chk("mid_in_frame", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_txd", txd, 1'b1);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_ren", ren, 1'b0);
        push(8'h5A);
        repeat (2) pclk();
        rst_n = 1'b1;
        rx_frame(w);
        chk("mid_after_frame", w, 10'h2B4);
        wait_idle(3 * FRAME);
        if (n0 < 0) chk("unused", n0, 0);

        // Randomized traffic with occasional enable toggling.
        for (int i = 0; i < 2000; i++) begin
            pclk();
            if (fifo_q.size() < 6 && $urandom_range(0, 19) == 0) push(8'($urandom));
            if ($urandom_range(0, 59) == 0) tx_en = ~tx_en;
        end
        tx_en = 1'b1;
        wait_idle((fifo_q.size() + 3) * FRAME);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
